// File: rtl/pwm_ramp_ctrl.sv
// PWM generator whose duty walks one count per STEP_DIV periods toward a requested target.
// Define PWM_RAMP_ESTOP_EN to add the active-high estop input that forces the duty to zero.
module pwm_ramp_ctrl #(
  parameter int MAX_COUNT = 100,
  parameter int STEP_DIV  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
`ifdef PWM_RAMP_ESTOP_EN
  input  logic       estop,
`endif
  input  logic       req_valid,
  input  logic [6:0] req_duty,
  output logic       req_ready,
  output logic [6:0] duty_cur,
  output logic       busy,
  output logic       done,
  output logic       pwm_out
);

  localparam int CW = (MAX_COUNT < 2) ? 1 : $clog2(MAX_COUNT + 1);
  localparam logic [CW-1:0] CNT_TOP = CW'(MAX_COUNT);
  localparam logic [7:0] STEP_LAST = 8'(STEP_DIV - 1);
  localparam logic [6:0] DUTY_MAX = 7'(MAX_COUNT);

  // IDLE: accept requests | RAMP_UP: +1 every STEP_DIV periods | RAMP_DOWN: -1 every STEP_DIV periods
  typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DOWN} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] counter;
  logic [7:0]    step_cnt, step_nx;
  logic [6:0]    target, target_nx, duty_nx, req_clamped;
  logic          done_nx, period_end, accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter <= '0;
    end else if (!en || counter == CNT_TOP) begin
      counter <= '0;
    end else begin
      counter <= counter + 1'b1;
    end
  end

  assign period_end = en && (counter == CNT_TOP);
  assign pwm_out    = en && (32'(duty_cur) > 32'(counter));

`ifdef PWM_RAMP_ESTOP_EN
  assign req_ready = (state == IDLE) && !estop;
`else
  assign req_ready = (state == IDLE);
`endif
  assign busy        = (state != IDLE);
  assign accept      = req_valid && req_ready;
  assign req_clamped = (32'(req_duty) > MAX_COUNT) ? DUTY_MAX : req_duty;

  always_comb begin
    state_nx  = state;
    step_nx   = step_cnt;
    target_nx = target;
    duty_nx   = duty_cur;
    done_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          target_nx = req_clamped;
          step_nx   = '0;
          if (req_clamped > duty_cur) begin
            state_nx = RAMP_UP;
          end else if (req_clamped < duty_cur) begin
            state_nx = RAMP_DOWN;
          end else begin
            done_nx = 1'b1;
          end
        end
      end
      RAMP_UP, RAMP_DOWN: begin
        if (period_end) begin
          if (step_cnt == STEP_LAST) begin
            step_nx = '0;
            duty_nx = (state == RAMP_UP) ? duty_cur + 7'd1 : duty_cur - 7'd1;
            if (duty_nx == target) begin
              state_nx = IDLE;
              done_nx  = 1'b1;
            end
          end else begin
            step_nx = step_cnt + 8'd1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
`ifdef PWM_RAMP_ESTOP_EN
    if (estop) begin
      state_nx  = IDLE;
      step_nx   = '0;
      target_nx = '0;
      duty_nx   = '0;
      done_nx   = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      step_cnt <= '0;
      target   <= '0;
      duty_cur <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      step_cnt <= step_nx;
      target   <= target_nx;
      duty_cur <= duty_nx;
      done     <= done_nx;
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Scoreboard bench for pwm_ramp_ctrl: requests push expected duty steps and done pulses with
// their clock cycle; a negedge monitor pops and compares whenever duty_cur changes or done fires.
module tb_pwm_ramp_ctrl;
  localparam int MC  = 100;
  localparam int SD  = 2;
  localparam int PER = MC + 1;

  logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0, req_valid = 1'b0;
  logic [6:0] req_duty = '0;
  logic       req_ready, busy, done, pwm_out;
  logic [6:0] duty_cur;
`ifdef PWM_RAMP_ESTOP_EN
  logic       estop = 1'b0;
`endif

  int tests_run = 0, fails = 0, cyc = 0, t0 = 0;
  bit quiet = 1'b0;
  logic [6:0] prev_duty = '0;

  typedef struct {int kind; int val; int at;} evt_t;
  evt_t q[$];

  pwm_ramp_ctrl #(.MAX_COUNT(MC), .STEP_DIV(SD)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
`ifdef PWM_RAMP_ESTOP_EN
    .estop(estop),
`endif
    .req_valid(req_valid),
    .req_duty(req_duty),
    .req_ready(req_ready),
    .duty_cur(duty_cur),
    .busy(busy),
    .done(done),
    .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc - t0);
    end
  endtask

  task automatic push(input int kind, input int val, input int at);
    evt_t e;
    e.kind = kind;
    e.val  = val;
    e.at   = at;
    q.push_back(e);
  endtask

  // kind 0 = duty change, kind 1 = done pulse; steps land on every SD-th period end after acceptance
  task automatic push_ramp(input int from, input int to, input int ph, input int after);
    int f, d, n;
    f = ph + PER * ((after - ph) / PER + 1);
    d = from;
    n = 0;
    while (d != to) begin
      d += (to > from) ? 1 : -1;
      n++;
      push(0, d, f + (n * SD - 1) * PER);
    end
    push(1, to, f + (n * SD - 1) * PER);
  endtask

  task automatic score(input int kind, input int val);
    evt_t e;
    tests_run++;
    if (q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_%s: value %0d at cycle %0d, no event expected",
               (kind != 0) ? "done" : "duty", val, cyc - t0);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.val != val || e.at != cyc) begin
        fails++;
        $display("FAIL event: got kind %0d value %0d cycle %0d, expected kind %0d value %0d cycle %0d",
                 kind, val, cyc - t0, e.kind, e.val, e.at - t0);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n || quiet) begin
      prev_duty = duty_cur;
    end else begin
      if (duty_cur != prev_duty) begin
        score(0, int'(duty_cur));
        prev_duty = duty_cur;
      end
      if (done) score(1, int'(duty_cur));
    end
  end

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    en = 1'b1;
    req_valid = 1'b0;
`ifdef PWM_RAMP_ESTOP_EN
    estop = 1'b0;
`endif
    #1;
    chk({tag, "_duty"}, int'(duty_cur), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_ready"}, int'(req_ready), 1);
    chk({tag, "_pwm"}, int'(pwm_out), 0);
    q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    t0 = cyc;
  endtask

  task automatic req(input int d, output int acc);
    @(negedge clk);
    chk("req_ready_idle", int'(req_ready), 1);
    req_valid = 1'b1;
    req_duty = 7'(d);
    @(posedge clk);
    #1;
    acc = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n = 0;
    while (q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_pending_events"}, q.size(), 0);
    q.delete();
  endtask

  task automatic wait_duty(input string name, input int val, input int limit);
    int n = 0;
    while (int'(duty_cur) != val && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(duty_cur), val);
  endtask

  task automatic pwm_count(input string name, input int exp);
    int hi = 0;
    repeat (PER) begin
      @(negedge clk);
      hi += int'(pwm_out);
    end
    chk(name, hi, exp);
  endtask

  initial begin
    int acc, bad, base;

    // ramp up to 3, with a stray request during the ramp that must be ignored
    do_reset("reset");
    pwm_count("pwm_high_at_duty0", 0);
    do_reset("reset2");
    req(3, acc);
    push(0, 1, t0 + 202);
    push(0, 2, t0 + 404);
    push(0, 3, t0 + 606);
    push(1, 3, t0 + 606);
    @(negedge clk);
    chk("ramp_busy", int'(busy), 1);
    chk("ramp_ready", int'(req_ready), 0);
    req_valid = 1'b1;
    req_duty = 7'd0;
    repeat (10) @(negedge clk);
    req_valid = 1'b0;
    wait_drain("ramp_up", 800);
    @(negedge clk);
    chk("after_ramp_busy", int'(busy), 0);
    chk("after_ramp_ready", int'(req_ready), 1);
    chk("after_ramp_done", int'(done), 0);
    pwm_count("pwm_high_at_duty3", 3);

    // ramp to 5, then an equal request
    req(5, acc);
    push_ramp(3, 5, t0, acc);
    wait_drain("ramp_to5", 700);
    req(5, acc);
    push(1, 5, acc);
    @(negedge clk);
    chk("equal_busy", int'(busy), 0);
    chk("equal_duty", int'(duty_cur), 5);
    wait_drain("equal", 5);

    // clamp to 100, then ramp down to 98
    req(120, acc);
    push_ramp(5, 100, t0, acc);
    wait_drain("clamp", 20000);
    pwm_count("pwm_high_at_duty100", 100);
    req(98, acc);
    push_ramp(100, 98, t0, acc);
    wait_drain("ramp_down", 700);

    // en=0 mid-ramp freezes everything, ramp resumes from 2
    do_reset("reset3");
    req(6, acc);
    push_ramp(0, 6, t0, acc);
    wait_duty("en_reach2", 2, 600);
    repeat (50) @(negedge clk);
    en = 1'b0;
    q.delete();
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (pwm_out !== 1'b0) bad++;
    end
    chk("en0_pwm_high_cycles", bad, 0);
    chk("en0_duty_hold", int'(duty_cur), 2);
    chk("en0_busy", int'(busy), 1);
    en = 1'b1;
    base = cyc;
    push_ramp(2, 6, base, base);
    wait_drain("en_resume", 1500);

    // asynchronous reset mid-ramp at duty 40
    do_reset("reset4");
    req(50, acc);
    push_ramp(0, 50, t0, acc);
    wait_duty("reach40", 40, 9000);
    do_reset("midramp_reset");

`ifdef PWM_RAMP_ESTOP_EN
    req(50, acc);
    push_ramp(0, 50, t0, acc);
    wait_duty("estop_reach2", 2, 600);
    quiet = 1'b1;
    q.delete();
    estop = 1'b1;
    @(negedge clk);
    chk("estop_duty", int'(duty_cur), 0);
    chk("estop_busy", int'(busy), 0);
    chk("estop_ready", int'(req_ready), 0);
    bad = 0;
    req_valid = 1'b1;
    req_duty = 7'd10;
    repeat (20) begin
      @(negedge clk);
      if (done !== 1'b0) bad++;
    end
    req_valid = 1'b0;
    chk("estop_done_pulses", bad, 0);
    estop = 1'b0;
    #1;
    chk("estop_release_ready", int'(req_ready), 1);
    repeat (3) @(negedge clk);
    chk("estop_release_duty", int'(duty_cur), 0);
    chk("estop_release_busy", int'(busy), 0);
    quiet = 1'b0;
`endif

    chk("scoreboard_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/pwm_ramp_ctrl.md
PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 SHALL have parameter MAX_COUNT, default 100: top value of the period counter, so one PWM period is MAX_COUNT+1 clocks.
REQ-002 SHALL have parameter STEP_DIV, default 4: number of PWM periods per duty step during a ramp; legal range 1..255.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port en, input, 1 bit: run enable for the period counter and the ramp.
REQ-006 SHALL have port req_valid, input, 1 bit: a new target-duty request is present.
REQ-007 SHALL have port req_duty, input, 7 bits: the requested target duty.
REQ-008 SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-009 SHALL have port duty_cur, output, 7 bits: the duty currently applied.
REQ-010 SHALL have port busy, output, 1 bit: a ramp is in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when the target is reached.
REQ-012 SHALL have port pwm_out, output, 1 bit: the PWM waveform.

Function
REQ-013 SHALL count the period counter 0..MAX_COUNT and wrap to 0; it advances once per clk while en=1.
REQ-014 SHALL define period_end as (counter == MAX_COUNT) with en=1.
REQ-015 SHALL drive pwm_out combinationally as en && (duty_cur > counter), so duty 0 is always low and duty MAX_COUNT is high for MAX_COUNT of the MAX_COUNT+1 cycles.
REQ-016 SHALL implement an FSM with states IDLE, RAMP_UP and RAMP_DOWN; busy=1 exactly in the RAMP states.
REQ-017 SHALL assert req_ready=1 only in IDLE; a request is accepted on any cycle with req_valid && req_ready.
REQ-018 SHALL clamp an accepted req_duty above MAX_COUNT to MAX_COUNT before storing it as the target.
REQ-019 SHALL, on acceptance, go to RAMP_UP if target > duty_cur or RAMP_DOWN if target < duty_cur; if target == duty_cur it SHALL stay in IDLE and pulse done on the next cycle.
REQ-020 SHALL, in a RAMP state, clear the step counter on entry and increment it on each period_end.
REQ-021 SHALL, on the period_end where the step counter equals STEP_DIV-1, change duty_cur by exactly +1 or -1 and clear the step counter.
REQ-022 SHALL update duty_cur only on a period_end, so the duty never changes mid-period.
REQ-023 SHALL, on the cycle duty_cur becomes equal to the target, return to IDLE and pulse done for exactly one cycle.
REQ-024 SHALL NOT step duty_cur in a cycle where it accepts a request, even if that cycle is a period_end.
REQ-025 SHALL, while en=0: hold the counter at 0, freeze the FSM, step counter and duty_cur, keep req_ready as defined by the state, and still accept requests while in IDLE.
REQ-026 SHALL ignore req_valid while not in IDLE; a request that is not accepted is not stored.

Reset
REQ-027 SHALL, with rst_n=0 at any time including mid-ramp, immediately set counter=0, step counter=0, target=0, duty_cur=0, state=IDLE, req_ready=1, busy=0, done=0 and pwm_out=0.
REQ-028 SHALL resume counting on the first clk edge after rst_n rises, provided en=1.

Configuration
REQ-029 SHALL use the macro PWM_RAMP_ESTOP_EN: when defined, the block has an extra input port estop (1 bit, active-high).
REQ-030 SHALL, with PWM_RAMP_ESTOP_EN defined and estop=1, on the next edge force duty_cur=0, target=0 and state=IDLE, hold req_ready=0 and never pulse done; the counter keeps running.
REQ-031 SHALL, with PWM_RAMP_ESTOP_EN undefined, have no estop port and no estop logic.

Verification (MAX_COUNT=100, STEP_DIV=2)
REQ-032 SHALL test ramp-up: reset, en=1, request 3 -> busy=1; duty_cur becomes 1, 2, 3 at the 2nd, 4th and 6th period_end after acceptance; done pulses once; req_ready returns to 1.
REQ-033 SHALL test clamp and ramp-down: request 120 -> target 100 and the ramp reaches 100; then request 98 -> duty 99 then 98, one step per 2 periods; then done.
REQ-034 SHALL test an equal request: with duty_cur=5, request 5 -> no state change, done=1 the next cycle, busy stays 0.
REQ-035 SHALL test en=0 mid-ramp: en=0 with duty 2 toward 6 -> counter=0, pwm_out=0, duty_cur holds at 2; en=1 -> the ramp resumes from 2.
REQ-036 SHALL test reset mid-ramp: rst_n=0 at duty 40 -> all outputs at their reset values without waiting for a clock edge.
REQ-037 SHALL test estop when PWM_RAMP_ESTOP_EN is defined: estop=1 during a ramp to 50 -> duty_cur=0, req_ready=0, no done; estop=0 -> req_ready=1.
